// File: rtl/tdm_demux4.sv
// Receive side of the 4:1 TDM link: re-splits slot-ordered samples onto four
// registered outputs once per frame, with HUNT/LOCKED frame alignment.
module tdm_demux4 #(
  parameter int unsigned WIDTH      = 1,
  parameter int unsigned MISS_LIMIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] din,
  input  logic             sof,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [1:0]       sel,
  output logic             frame_valid,
  output logic             locked,
  output logic             sync_err
);

  localparam int unsigned MW = 3;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] stage0_q, stage0_d;
  logic [WIDTH-1:0] stage1_q, stage1_d;
  logic [WIDTH-1:0] stage2_q, stage2_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic [1:0]       sel_q, sel_d;
  logic [MW-1:0]    miss_q, miss_d;
  logic [MW-1:0]    miss_inc;
  logic             fv_q, fv_d;
  logic             err_q, err_d;
  logic             locked_q, locked_d;

  assign miss_inc = miss_q + MW'(1);

  // State register and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_HUNT;
      stage0_q <= '0;
      stage1_q <= '0;
      stage2_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      d_q      <= '0;
      sel_q    <= 2'd0;
      miss_q   <= '0;
      fv_q     <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      stage0_q <= stage0_d;
      stage1_q <= stage1_d;
      stage2_q <= stage2_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      d_q      <= d_d;
      sel_q    <= sel_d;
      miss_q   <= miss_d;
      fv_q     <= fv_d;
      err_q    <= err_d;
      locked_q <= locked_d;
    end
  end

  // Next-state and output decode; idle cycles hold everything except the pulses
  always_comb begin
    state_d  = state_q;
    stage0_d = stage0_q;
    stage1_d = stage1_q;
    stage2_d = stage2_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    d_d      = d_q;
    sel_d    = sel_q;
    miss_d   = miss_q;
    fv_d     = 1'b0;
    err_d    = 1'b0;

    if (din_valid) begin
      case (state_q)
        ST_HUNT: begin
          if (sof) begin
            stage0_d = din;
            sel_d    = 2'd1;
            miss_d   = '0;
            state_d  = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (sel_q == 2'd0) begin
            if (sof) begin
              stage0_d = din;
              sel_d    = 2'd1;
              miss_d   = '0;
            end else begin
              err_d = 1'b1;
              // Missing sof: tolerated as slot 0 until the limit is hit
              if (miss_inc >= MW'(MISS_LIMIT)) begin
                state_d = ST_HUNT;
                sel_d   = 2'd0;
                miss_d  = '0;
              end else begin
                miss_d   = miss_inc;
                stage0_d = din;
                sel_d    = 2'd1;
              end
            end
          end else if (sof) begin
            // Early sof: drop the partial frame and restart at slot 0
            err_d    = 1'b1;
            stage0_d = din;
            sel_d    = 2'd1;
            miss_d   = '0;
          end else begin
            case (sel_q)
              2'd1: stage1_d = din;
              2'd2: stage2_d = din;
              2'd3: begin
                a_d  = stage0_q;
                b_d  = stage1_q;
                c_d  = stage2_q;
                d_d  = din;
                fv_d = 1'b1;
              end
              default: ;
            endcase
            sel_d = sel_q + 2'd1;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end

    locked_d = (state_d == ST_LOCKED);
  end

  assign a           = a_q;
  assign b           = b_q;
  assign c           = c_q;
  assign d           = d_q;
  assign sel         = sel_q;
  assign frame_valid = fv_q;
  assign locked      = locked_q;
  assign sync_err    = err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4: each scenario steps a table of {rst,valid,sof,din}
// and compares {a,b,c,d,sel,frame_valid,locked,sync_err} after every edge.
module tb_tdm_demux4;

  logic       clk = 1'b0;
  logic       rst;
  logic       din_valid;
  logic [0:0] din;
  logic       sof;
  logic [0:0] a, b, c, d;
  logic [1:0] sel;
  logic       frame_valid, locked, sync_err;

  int checks   = 0;
  int failures = 0;

  tdm_demux4 #(.WIDTH(1), .MISS_LIMIT(2)) dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .sof(sof),
    .a(a), .b(b), .c(c), .d(d), .sel(sel),
    .frame_valid(frame_valid), .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] snap();
    return {a, b, c, d, sel, frame_valid, locked, sync_err};
  endfunction

  // Apply one cycle of stimulus {rst,valid,sof,din}; return 1ns after the edge
  task automatic drive(input logic [3:0] st);
    {rst, din_valid, sof, din} = st;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(4'b1111);
      checks++;
      if (snap() !== 9'b0000_00_000) begin
        failures++;
        $display("FAIL reset step %0d: got %b expected %b", i, snap(), 9'b0000_00_000);
      end
    end
  endtask

  task automatic test_clean_frame();
    logic [3:0] st [10] = '{4'b0110, 4'b0101, 4'b0100, 4'b0100, 4'b0000,
                            4'b0111, 4'b0100, 4'b0101, 4'b0101, 4'b0000};
    logic [8:0] ex [10] = '{9'b0000_01_010, 9'b0000_10_010, 9'b0000_11_010,
                            9'b0100_00_110, 9'b0100_00_010,
                            9'b0100_01_010, 9'b0100_10_010, 9'b0100_11_010,
                            9'b1011_00_110, 9'b1011_00_010};
    for (int i = 0; i < 10; i++) begin
      drive(st[i]);
      checks++;
      if (snap() !== ex[i]) begin
        failures++;
        $display("FAIL clean_frame step %0d: got %b expected %b", i, snap(), ex[i]);
      end
    end
  endtask

  task automatic test_gaps();
    logic [3:0] st [8] = '{4'b0110, 4'b0000, 4'b0101, 4'b0000,
                           4'b0100, 4'b0000, 4'b0100, 4'b0000};
    logic [8:0] ex [8] = '{9'b1011_01_010, 9'b1011_01_010, 9'b1011_10_010,
                           9'b1011_10_010, 9'b1011_11_010, 9'b1011_11_010,
                           9'b0100_00_110, 9'b0100_00_010};
    for (int i = 0; i < 8; i++) begin
      drive(st[i]);
      checks++;
      if (snap() !== ex[i]) begin
        failures++;
        $display("FAIL gaps step %0d: got %b expected %b", i, snap(), ex[i]);
      end
    end
  endtask

  task automatic test_early_sof();
    logic [3:0] st [7] = '{4'b0111, 4'b0101, 4'b0110, 4'b0100,
                           4'b0101, 4'b0101, 4'b0000};
    logic [8:0] ex [7] = '{9'b0100_01_010, 9'b0100_10_010, 9'b0100_01_011,
                           9'b0100_10_010, 9'b0100_11_010, 9'b0011_00_110,
                           9'b0011_00_010};
    for (int i = 0; i < 7; i++) begin
      drive(st[i]);
      checks++;
      if (snap() !== ex[i]) begin
        failures++;
        $display("FAIL early_sof step %0d: got %b expected %b", i, snap(), ex[i]);
      end
    end
  endtask

  // Miss, good frame (clears count), miss, miss -> HUNT, ignored samples, relock
  task automatic test_lost_sync();
    logic [3:0] st [24] = '{4'b0101, 4'b0100, 4'b0100, 4'b0101,
                            4'b0110, 4'b0101, 4'b0101, 4'b0100,
                            4'b0101, 4'b0101, 4'b0101, 4'b0101,
                            4'b0100, 4'b0101, 4'b0101, 4'b0000,
                            4'b0111, 4'b0100, 4'b0100, 4'b0100,
                            4'b0000, 4'b0000, 4'b0000, 4'b0000};
    logic [8:0] ex [24] = '{9'b0011_01_011, 9'b0011_10_010, 9'b0011_11_010, 9'b1001_00_110,
                            9'b1001_01_010, 9'b1001_10_010, 9'b1001_11_010, 9'b0110_00_110,
                            9'b0110_01_011, 9'b0110_10_010, 9'b0110_11_010, 9'b1111_00_110,
                            9'b1111_00_001, 9'b1111_00_000, 9'b1111_00_000, 9'b1111_00_000,
                            9'b1111_01_010, 9'b1111_10_010, 9'b1111_11_010, 9'b1000_00_110,
                            9'b1000_00_010, 9'b1000_00_010, 9'b1000_00_010, 9'b1000_00_010};
    for (int i = 0; i < 24; i++) begin
      drive(st[i]);
      checks++;
      if (snap() !== ex[i]) begin
        failures++;
        $display("FAIL lost_sync step %0d: got %b expected %b", i, snap(), ex[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [3:0] st [9] = '{4'b0111, 4'b0101, 4'b1101, 4'b0101, 4'b0100,
                           4'b0110, 4'b0101, 4'b0100, 4'b0100};
    logic [8:0] ex [9] = '{9'b1000_01_010, 9'b1000_10_010, 9'b0000_00_000,
                           9'b0000_00_000, 9'b0000_00_000, 9'b0000_01_010,
                           9'b0000_10_010, 9'b0000_11_010, 9'b0100_00_110};
    for (int i = 0; i < 9; i++) begin
      drive(st[i]);
      checks++;
      if (snap() !== ex[i]) begin
        failures++;
        $display("FAIL mid_reset step %0d: got %b expected %b", i, snap(), ex[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] st [9] = '{4'b0111, 4'b0100, 4'b0101, 4'b0101,
                           4'b0110, 4'b0100, 4'b0101, 4'b0100, 4'b0000};
    logic [8:0] ex [9] = '{9'b0100_01_010, 9'b0100_10_010, 9'b0100_11_010,
                           9'b1011_00_110, 9'b1011_01_010, 9'b1011_10_010,
                           9'b1011_11_010, 9'b0010_00_110, 9'b0010_00_010};
    for (int i = 0; i < 9; i++) begin
      drive(st[i]);
      checks++;
      if (snap() !== ex[i]) begin
        failures++;
        $display("FAIL back_to_back step %0d: got %b expected %b", i, snap(), ex[i]);
      end
    end
  endtask

  initial begin
    {rst, din_valid, sof, din} = 4'b1000;
    test_reset();
    test_clean_frame();
    test_gaps();
    test_early_sof();
    test_lost_sync();
    test_mid_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
